// File: rtl/jtdd_snd_pkg.sv
// rtl/jtdd_snd_pkg.sv - shared types, gain format and width helpers for the sound mixer
package jtdd_snd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2
  } mix_state_t;

  localparam logic [7:0] GAIN_ONE = 8'h10;
  localparam int         GFRAC    = 4;

  // Product of a W-bit sample and a 9-bit zero-extended gain
  function automatic int prod_width(input int w);
    return w + 9;
  endfunction

  function automatic int acc_width(input int w, input int ch);
    return w + 9 + $clog2(ch);
  endfunction

endpackage

// File: rtl/jtdd_mix_sat.sv
// rtl/jtdd_mix_sat.sv - drops the gain fraction from an accumulator and clamps it to WOUT bits
module jtdd_mix_sat
  import jtdd_snd_pkg::*;
#(
  parameter int AW   = 29,
  parameter int WOUT = 16
) (
  input  logic signed [AW-1:0]   acc,
  output logic signed [WOUT-1:0] dout,
  output logic                   ovf
);

  logic signed [AW-1:0] r;
  logic [AW-WOUT:0]     hi;

  always_comb begin
    r    = acc >>> GFRAC;
    // in range only when every bit above the output sign bit copies it
    hi   = r[AW-1:WOUT-1];
    ovf  = !((&hi) || !(|hi));
    dout = r[WOUT-1:0];
    if (ovf) begin
      if (r[AW-1]) dout = {1'b1, {(WOUT-1){1'b0}}};
      else         dout = {1'b0, {(WOUT-1){1'b1}}};
    end
  end

endmodule

// File: rtl/jtdd_snd_mixer_n.sv
// rtl/jtdd_snd_mixer_n.sv - time-multiplexed N-channel mixer with programmable gains, mute and saturation
module jtdd_snd_mixer_n
  import jtdd_snd_pkg::*;
#(
  parameter int         CH       = 4,
  parameter int         W        = 16,
  parameter int         WOUT     = 16,
  parameter logic [7:0] GAIN_DEF = GAIN_ONE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  input  logic [CH*W-1:0]         ch_in,
  input  logic [CH-1:0]           mute,
  input  logic                    gain_we,
  input  logic [$clog2(CH)-1:0]   gain_addr,
  input  logic [7:0]              gain_din,
  output logic signed [WOUT-1:0]  mixed,
  output logic                    sample,
  output logic                    peak,
  output logic                    busy,
  output logic                    overrun
);

  localparam int IW = $clog2(CH);
  localparam int PW = prod_width(W);
  localparam int AW = acc_width(W, CH);

  mix_state_t           state;
  logic [IW-1:0]        idx;
  logic signed [AW-1:0] acc;
  logic [7:0]           gain    [CH];
  logic [7:0]           sh_gain [CH];
  logic signed [W-1:0]  sh_in   [CH];
  logic [CH-1:0]        sh_mute;

  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [WOUT-1:0] sat_out;
  logic                   sat_ovf;

  always_comb begin
    prod     = PW'(sh_in[idx]) * PW'($signed({1'b0, sh_gain[idx]}));
    prod_ext = prod;
  end

  // a strobe during MAC/SAT is dropped; flag it in the same cycle it arrives
  assign overrun = cen & busy;

  jtdd_mix_sat #(.AW(AW), .WOUT(WOUT)) u_sat (
    .acc  (acc),
    .dout (sat_out),
    .ovf  (sat_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      acc     <= '0;
      mixed   <= '0;
      sample  <= 1'b0;
      peak    <= 1'b0;
      busy    <= 1'b0;
      sh_mute <= '0;
      for (int k = 0; k < CH; k++) begin
        gain[k]    <= GAIN_DEF;
        sh_gain[k] <= GAIN_DEF;
        sh_in[k]   <= '0;
      end
    end else begin
      sample <= 1'b0;
      if (gain_we && (32'(gain_addr) < CH)) gain[gain_addr] <= gain_din;

      case (state)
        ST_IDLE: begin
          if (cen) begin
            // snapshot sees the pre-write gain file when gain_we coincides
            for (int k = 0; k < CH; k++) begin
              sh_in[k]   <= ch_in[k*W +: W];
              sh_gain[k] <= gain[k];
            end
            sh_mute <= mute;
            acc     <= '0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (!sh_mute[idx]) acc <= acc + prod_ext;
          if (idx == IW'(CH-1)) state <= ST_SAT;
          else                  idx   <= idx + IW'(1);
        end
        ST_SAT: begin
          mixed  <= sat_out;
          peak   <= sat_ovf;
          sample <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtdd_snd_mixer_n.sv
// tb/tb_jtdd_snd_mixer_n.sv - directed self-checking bench for the N-channel mixer
module tb_jtdd_snd_mixer_n;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cen = 1'b0;
  logic [63:0]        ch_in = '0;
  logic [3:0]         mute = '0;
  logic               gain_we = 1'b0;
  logic [1:0]         gain_addr = '0;
  logic [7:0]         gain_din = '0;
  logic signed [15:0] mixed;
  logic               sample, peak, busy, overrun;

  int errors = 0;
  int checks = 0;
  int lat;
  int extra;

  jtdd_snd_mixer_n #(.CH(4), .W(16), .WOUT(16), .GAIN_DEF(8'h10)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .ch_in     (ch_in),
    .mute      (mute),
    .gain_we   (gain_we),
    .gain_addr (gain_addr),
    .gain_din  (gain_din),
    .mixed     (mixed),
    .sample    (sample),
    .peak      (peak),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic set_in(input int a, input int b, input int c, input int d);
    ch_in = {16'(d), 16'(c), 16'(b), 16'(a)};
  endtask

  task automatic write_gain(input int ch, input logic [7:0] g);
    @(negedge clk);
    gain_we = 1'b1; gain_addr = 2'(ch); gain_din = g;
    @(negedge clk);
    gain_we = 1'b0;
  endtask

  // cen is high for the cycle of one negedge; returns at the next negedge (cen+1)
  task automatic strobe();
    @(negedge clk);
    cen = 1'b1;
    @(negedge clk);
    cen = 1'b0;
  endtask

  task automatic wait_sample(input int start, output int n);
    n = start;
    while (!sample && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!sample) check("sample_timeout", 32'(n), 32'd6);
  endtask

  task automatic count_samples(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (sample) cnt++;
    end
  endtask

  task automatic mix(input string tag, input int a, input int b, input int c, input int d,
                     input int exp, input logic exp_peak);
    set_in(a, b, c, d);
    strobe();
    wait_sample(1, lat);
    check({tag, "_lat"}, 32'(lat), 32'd6);
    check({tag, "_mixed"}, mixed, 32'(exp));
    check({tag, "_peak"}, 32'(peak), 32'(exp_peak));
  endtask

  initial begin
    #2;
    check("rst_mixed", mixed, 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_peak", 32'(peak), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // unity mix with latency and handshake detail
    set_in(100, 200, -50, 0);
    strobe();
    check("busy_t1", 32'(busy), 32'd1);
    wait_sample(1, lat);
    check("unity_lat", 32'(lat), 32'd6);
    check("unity_mixed", mixed, 32'd250);
    check("unity_peak", 32'(peak), 32'd0);
    check("unity_busy_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("sample_one_clk", 32'(sample), 32'd0);
    check("mixed_held", mixed, 32'd250);

    write_gain(0, 8'h08);
    mix("half", 1000, 0, 0, 0, 500, 1'b0);
    write_gain(0, 8'h18);
    mix("one_half", 1000, 0, 0, 0, 1500, 1'b0);
    write_gain(0, 8'h08);
    mix("floor", -3, 0, 0, 0, -2, 1'b0);
    write_gain(0, 8'h10);

    mix("sat_pos", 32767, 32767, 32767, 32767, 32767, 1'b1);
    mix("sat_neg", -32768, -32768, -32768, -32768, -32768, 1'b1);
    mix("post_sat", 10, 10, 10, 10, 40, 1'b0);

    mute = 4'b0010;
    mix("mute", 1, 2, 3, 4, 8, 1'b0);

    // gain write coinciding with the cen that takes the snapshot
    set_in(1, 2, 3, 4);
    @(negedge clk);
    cen = 1'b1; gain_we = 1'b1; gain_addr = 2'd3; gain_din = 8'h20;
    @(negedge clk);
    cen = 1'b0; gain_we = 1'b0;
    wait_sample(1, lat);
    check("gain_same_clk_old", mixed, 32'd8);
    mix("gain_next_sample", 1, 2, 3, 4, 12, 1'b0);
    mute = 4'b0000;

    // second strobe at cen+3 is dropped
    set_in(5, 6, 7, 8);
    strobe();
    @(negedge clk);
    @(negedge clk);
    cen = 1'b1;
    set_in(100, 100, 100, 100);
    #1;
    check("overrun_pulse", 32'(overrun), 32'd1);
    @(negedge clk);
    cen = 1'b0;
    #1;
    check("overrun_one_clk", 32'(overrun), 32'd0);
    wait_sample(4, lat);
    check("overrun_lat", 32'(lat), 32'd6);
    check("overrun_mixed", mixed, 32'd34);
    count_samples(12, extra);
    check("overrun_no_extra", 32'(extra), 32'd0);

    // async reset mid-MAC with non-default gains
    write_gain(0, 8'h08);
    set_in(100, 100, 100, 100);
    strobe();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_mixed", mixed, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_peak", 32'(peak), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_samples(12, extra);
    check("abort_no_sample", 32'(extra), 32'd0);
    mix("gain_reset", 1000, 0, 0, 4000, 5000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtdd_snd_mixer_n.md
# jtdd_snd_mixer_n

Parametrised, time-multiplexed N-channel audio mixer for the sound board, with run-time programmable per-channel gains, a mute mask, saturation and peak flagging. It replaces fixed-gain, fixed-channel-count mixing: FM left/right, ADPCM voices and any future PSG or PCM source feed one instance. One shared multiplier accumulates the channels over consecutive clocks after each sample strobe.

## Interface
Parameters:
- CH, 4: number of input channels, 2..8.
- W, 16: signed width of each input channel.
- WOUT, 16: signed output width, WOUT <= W+4.
- GAIN_DEF, 8'h10: reset gain for every channel, unsigned 4.4 (8'h10 = 1.0).

Ports:
- clk  in  1  system clock (24 MHz)
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- cen  in  1  sample strobe, one clk wide
- ch_in  in  CH*W  packed signed inputs; channel k at [k*W +: W]
- mute  in  CH  bit k=1 removes channel k from the sum
- gain_we  in  1  gain register write enable
- gain_addr  in  clog2(CH)  channel whose gain is written
- gain_din  in  8  unsigned 4.4 gain value
- mixed  out  WOUT  signed mixed sample, held between updates
- sample  out  1  one-clk pulse when mixed updates
- peak  out  1  high while the held sample was saturated
- busy  out  1  high while accumulation is in progress
- overrun  out  1  one-clk pulse when cen arrives while busy

## Operation
- Gain file: CH x 8-bit registers. gain_we writes gain_din to gain[gain_addr] on the clock edge. An out-of-range gain_addr (CH not a power of 2) is ignored.
- FSM states: IDLE -> MAC -> SAT -> IDLE.
- IDLE: on cen, snapshot ch_in, mute and the whole gain file into shadow registers. Then clear acc, set idx=0, busy=1 and go to MAC.
- MAC: each clk adds to acc the product of shadow input[idx] (signed) and shadow gain[idx] (zero-extended, treated as signed), skipping the add if mute[idx]=1. idx then increments. After idx=CH-1, go to SAT.
- Product width: W+9. Accumulator width: W+9+clog2(CH). This never overflows.
- SAT: r = acc >>> 4 (arithmetic, floors toward -inf). Clamp r to [-2^(WOUT-1), 2^(WOUT-1)-1] and register it into mixed. Set peak=1 if clamping occurred, else 0. Pulse sample for one clk, clear busy and return to IDLE.
- cen while busy (MAC or SAT): the strobe is dropped and overrun pulses on the same clk. The current accumulation is unaffected.
- gain_we on the same clk as a cen snapshot: the snapshot takes the old gain; the new value applies from the next sample.
- Inputs and mute may change freely during MAC. Only the snapshot is used.

## Timing
- Reset values: mixed=0, sample=0, peak=0, busy=0, overrun=0, acc=0, FSM=IDLE, every gain=GAIN_DEF.
- Reset asserted mid-MAC or mid-SAT: the FSM returns to IDLE immediately, and no sample pulse is produced for the aborted accumulation.
- Latency: cen at cycle t -> busy from t+1. MAC occupies t+1..t+CH, SAT is t+CH+1, and sample, mixed and peak update at t+CH+2.
- Minimum cen spacing for no overrun: CH+2 clks. cen arriving exactly at t+CH+2 is accepted.
- mixed and peak hold their value until the next sample pulse.

## Structure
- Package jtdd_snd_pkg holds: the FSM state enum; the gain format constant GAIN_ONE=8'h10 and fractional bits GFRAC=4; and helper functions for the accumulator width, AW = W+9+clog2(CH).
- Sub-module jtdd_mix_sat: a combinational arithmetic-shift-and-clamp from AW to WOUT, with an overflow flag. It is reused by the later stereo variant.

## Test plan
- Reset then unity gains, CH=4, inputs 100, 200, -50, 0 -> mixed=250 at cen+6 clks, sample high 1 clk, peak=0.
- Gain writes: ch0 to 8'h08 with input 1000 -> 500. Set gain to 8'h18 -> 1500. Input -3 with gain 8'h08 -> -2 (floor).
- Saturation: all inputs 16'h7FFF at unity -> mixed=16'h7FFF, peak=1. All 16'h8000 -> 16'h8000, peak=1. A following sample of 10 on every channel -> 40, peak=0.
- Mute: mute=4'b0010, inputs 1, 2, 3, 4 -> 8. A gain write on the same clk as cen is not used until the following sample.
- cen issued at cen+3 -> overrun pulses once, with no extra sample. The mixed result is that of the first snapshot.
- Asynchronous rst asserted at cen+2 -> outputs 0 immediately and no sample pulse. All gains read back as GAIN_DEF: unity behaviour is seen on the next cen.
